// File: rtl/edid_block_parser.sv
// EDID base-block parser: header/checksum validation plus identity and first-DTD field extraction.
// Optional raw byte store with registered read port when EDID_RAW_STORE_EN is defined.
module edid_block_parser #(
  parameter int BLOCK_BYTES = 128,
  parameter int DTD_OFFSET  = 54
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        busy,
  output logic        done,
  output logic        header_ok,
  output logic        checksum_ok,
  output logic [15:0] mfg_id,
  output logic [15:0] product_code,
  output logic [7:0]  ext_count,
  output logic [15:0] pixel_clk_10khz,
  output logic [11:0] h_active,
  output logic [11:0] v_active,
  output logic [6:0]  byte_idx,
  output logic        overrun
`ifdef EDID_RAW_STORE_EN
  ,
  input  logic [6:0]  rd_addr,
  output logic [7:0]  rd_data
`endif
);

  typedef enum logic [2:0] {IDLE, HEADER, BODY, DONE, ABORT} state_t;

  localparam logic [6:0] LAST_IDX  = 7'(BLOCK_BYTES - 1);
  localparam logic [6:0] HDR_LAST  = 7'd7;
  localparam logic [6:0] MFG_HI    = 7'd8;
  localparam logic [6:0] MFG_LO    = 7'd9;
  localparam logic [6:0] PROD_LO   = 7'd10;
  localparam logic [6:0] PROD_HI   = 7'd11;
  localparam logic [6:0] EXT_IDX   = 7'd126;
  localparam logic [6:0] PCLK_LO   = 7'(DTD_OFFSET);
  localparam logic [6:0] PCLK_HI   = 7'(DTD_OFFSET + 1);
  localparam logic [6:0] HACT_LO   = 7'(DTD_OFFSET + 2);
  localparam logic [6:0] HACT_HI   = 7'(DTD_OFFSET + 4);
  localparam logic [6:0] VACT_LO   = 7'(DTD_OFFSET + 5);
  localparam logic [6:0] VACT_HI   = 7'(DTD_OFFSET + 7);

  state_t      state_q;
  logic [7:0]  acc_q;
  logic [7:0]  acc_d;
  logic [7:0]  hdr_exp_d;
  logic [6:0]  byte_idx_q;
  logic        busy_q, done_q, header_ok_q, checksum_ok_q, overrun_q;
  logic [15:0] mfg_id_q, product_code_q, pixel_clk_q;
  logic [7:0]  ext_count_q;
  logic [11:0] h_active_q, v_active_q;

  always_comb begin
    acc_d     = acc_q + byte_data;
    hdr_exp_d = (byte_idx_q == 7'd0 || byte_idx_q == HDR_LAST) ? 8'h00 : 8'hFF;
  end

  // start outranks every state and any coincident byte_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= 8'h00;
      byte_idx_q     <= 7'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      header_ok_q    <= 1'b0;
      checksum_ok_q  <= 1'b0;
      overrun_q      <= 1'b0;
      mfg_id_q       <= 16'h0;
      product_code_q <= 16'h0;
      pixel_clk_q    <= 16'h0;
      ext_count_q    <= 8'h0;
      h_active_q     <= 12'h0;
      v_active_q     <= 12'h0;
    end else if (start) begin
      state_q        <= HEADER;
      acc_q          <= 8'h00;
      byte_idx_q     <= 7'd0;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
      header_ok_q    <= 1'b0;
      checksum_ok_q  <= 1'b0;
      overrun_q      <= 1'b0;
      mfg_id_q       <= 16'h0;
      product_code_q <= 16'h0;
      pixel_clk_q    <= 16'h0;
      ext_count_q    <= 8'h0;
      h_active_q     <= 12'h0;
      v_active_q     <= 12'h0;
    end else begin
      case (state_q)
        IDLE: ;
        HEADER: if (byte_valid) begin
          acc_q      <= acc_d;
          byte_idx_q <= byte_idx_q + 7'd1;
          if (byte_data != hdr_exp_d) begin
            state_q     <= ABORT;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            header_ok_q <= 1'b0;
          end else if (byte_idx_q == HDR_LAST) begin
            state_q     <= BODY;
            header_ok_q <= 1'b1;
          end
        end
        BODY: if (byte_valid) begin
          acc_q <= acc_d;
          if (byte_idx_q == MFG_HI)  mfg_id_q[15:8]       <= byte_data;
          if (byte_idx_q == MFG_LO)  mfg_id_q[7:0]        <= byte_data;
          if (byte_idx_q == PROD_LO) product_code_q[7:0]  <= byte_data;
          if (byte_idx_q == PROD_HI) product_code_q[15:8] <= byte_data;
          if (byte_idx_q == EXT_IDX) ext_count_q          <= byte_data;
          if (byte_idx_q == PCLK_LO) pixel_clk_q[7:0]     <= byte_data;
          if (byte_idx_q == PCLK_HI) pixel_clk_q[15:8]    <= byte_data;
          if (byte_idx_q == HACT_LO) h_active_q[7:0]      <= byte_data;
          if (byte_idx_q == HACT_HI) h_active_q[11:8]     <= byte_data[7:4];
          if (byte_idx_q == VACT_LO) v_active_q[7:0]      <= byte_data;
          if (byte_idx_q == VACT_HI) v_active_q[11:8]     <= byte_data[7:4];
          // byte_idx parks on the last index until the next start
          if (byte_idx_q == LAST_IDX) begin
            checksum_ok_q <= (acc_d == 8'h00);
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= DONE;
          end else begin
            byte_idx_q <= byte_idx_q + 7'd1;
          end
        end
        DONE, ABORT: if (byte_valid) overrun_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign header_ok       = header_ok_q;
  assign checksum_ok     = checksum_ok_q;
  assign mfg_id          = mfg_id_q;
  assign product_code    = product_code_q;
  assign ext_count       = ext_count_q;
  assign pixel_clk_10khz = pixel_clk_q;
  assign h_active        = h_active_q;
  assign v_active        = v_active_q;
  assign byte_idx        = byte_idx_q;
  assign overrun         = overrun_q;

`ifdef EDID_RAW_STORE_EN
  logic [7:0] mem_q [BLOCK_BYTES];
  logic [7:0] rd_data_q;

  // Array is deliberately left uninitialised so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (byte_valid && !start && (state_q == HEADER || state_q == BODY))
      mem_q[byte_idx_q] <= byte_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= 8'h00;
    else        rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_edid_block_parser.sv
// Directed bench for edid_block_parser: expected values queued per step, popped and asserted on output.
// Exercises the raw store read port when EDID_RAW_STORE_EN is defined.
module tb_edid_block_parser;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid;
  logic [7:0]  byte_data;
  logic        busy, done, header_ok, checksum_ok, overrun;
  logic [15:0] mfg_id, product_code, pixel_clk_10khz;
  logic [7:0]  ext_count;
  logic [11:0] h_active, v_active;
  logic [6:0]  byte_idx;
`ifdef EDID_RAW_STORE_EN
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;
`endif

  always #5 clk = ~clk;

  edid_block_parser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .busy(busy), .done(done), .header_ok(header_ok), .checksum_ok(checksum_ok),
    .mfg_id(mfg_id), .product_code(product_code), .ext_count(ext_count),
    .pixel_clk_10khz(pixel_clk_10khz), .h_active(h_active), .v_active(v_active),
    .byte_idx(byte_idx), .overrun(overrun)
`ifdef EDID_RAW_STORE_EN
    , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [7:0]  good_blk [128];
  logic [7:0]  cur_blk  [128];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    total_cnt++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    $display("byte idx_after=%0d data=%02h busy=%0b done=%0b", byte_idx, b, busy, done);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("start busy=%0b byte_idx=%0d", busy, byte_idx);
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(cur_blk[i]);
  endtask

  task automatic check_good(input logic exp_ck);
    exp_push("done", 32'd1);            cmp(32'(done));
    exp_push("busy_end", 32'd0);        cmp(32'(busy));
    exp_push("header_ok", 32'd1);       cmp(32'(header_ok));
    exp_push("checksum_ok", 32'(exp_ck)); cmp(32'(checksum_ok));
    exp_push("mfg_id", 32'h10AC);       cmp(32'(mfg_id));
    exp_push("product_code", 32'hA040); cmp(32'(product_code));
    exp_push("pixel_clk", 32'h3A02);    cmp(32'(pixel_clk_10khz));
    exp_push("h_active", 32'h780);      cmp(32'(h_active));
    exp_push("v_active", 32'h438);      cmp(32'(v_active));
    exp_push("ext_count", 32'h01);      cmp(32'(ext_count));
    exp_push("byte_idx_end", 32'd127);  cmp(32'(byte_idx));
  endtask

  task automatic check_all_zero(input string pfx);
    exp_push({pfx, "_busy"}, 0);     cmp(32'(busy));
    exp_push({pfx, "_done"}, 0);     cmp(32'(done));
    exp_push({pfx, "_header"}, 0);   cmp(32'(header_ok));
    exp_push({pfx, "_cksum"}, 0);    cmp(32'(checksum_ok));
    exp_push({pfx, "_mfg"}, 0);      cmp(32'(mfg_id));
    exp_push({pfx, "_pclk"}, 0);     cmp(32'(pixel_clk_10khz));
    exp_push({pfx, "_hact"}, 0);     cmp(32'(h_active));
    exp_push({pfx, "_idx"}, 0);      cmp(32'(byte_idx));
    exp_push({pfx, "_overrun"}, 0);  cmp(32'(overrun));
  endtask

  initial begin
    logic [7:0] sum;
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
`ifdef EDID_RAW_STORE_EN
    rd_addr = 7'd0;
`endif
    // Reference block: real header, identity, DTD fields, corrected checksum
    for (int i = 0; i < 128; i++) good_blk[i] = 8'((i * 37) + 11);
    good_blk[0] = 8'h00;
    for (int i = 1; i < 7; i++) good_blk[i] = 8'hFF;
    good_blk[7]  = 8'h00;
    good_blk[8]  = 8'h10; good_blk[9]  = 8'hAC;
    good_blk[10] = 8'h40; good_blk[11] = 8'hA0;
    good_blk[54] = 8'h02; good_blk[55] = 8'h3A;
    good_blk[56] = 8'h80; good_blk[58] = 8'h70;
    good_blk[59] = 8'h38; good_blk[61] = 8'h40;
    good_blk[126] = 8'h01;
    sum = 8'h00;
    for (int i = 0; i < 127; i++) sum = sum + good_blk[i];
    good_blk[127] = 8'h00 - sum;

    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Valid block with per-field latency checks
    cur_blk = good_blk;
    do_start();
    exp_push("start_busy", 1); cmp(32'(busy));
    exp_push("start_idx", 0);  cmp(32'(byte_idx));
    for (int i = 0; i < 128; i++) begin
      send_byte(cur_blk[i]);
      if (i == 9)   begin exp_push("mfg_latency", 32'h10AC); cmp(32'(mfg_id)); end
      if (i == 55)  begin exp_push("pclk_latency", 32'h3A02); cmp(32'(pixel_clk_10khz)); end
      if (i == 126) begin exp_push("done_early", 0); cmp(32'(done)); end
    end
    check_good(1'b1);
    send_byte(8'h55);
    exp_push("overrun_done", 1);   cmp(32'(overrun));
    exp_push("idx_no_wrap", 127);  cmp(32'(byte_idx));
`ifdef EDID_RAW_STORE_EN
    rd_addr = 7'd8;
    tick();
    exp_push("rd_addr8", 32'h10); cmp(32'(rd_data));
    rd_addr = 7'd127;
    tick();
    exp_push("rd_addr127", 32'(good_blk[127])); cmp(32'(rd_data));
`endif

    // Header corruption at byte 3
    cur_blk = good_blk;
    cur_blk[3] = 8'hFE;
    do_start();
    exp_push("hdr_overrun_clr", 0); cmp(32'(overrun));
    send_range(0, 2);
    exp_push("hdr_not_done", 0); cmp(32'(done));
    send_range(3, 3);
    exp_push("abort_done", 1);    cmp(32'(done));
    exp_push("abort_header", 0);  cmp(32'(header_ok));
    exp_push("abort_busy", 0);    cmp(32'(busy));
    exp_push("abort_overrun", 0); cmp(32'(overrun));
    send_range(4, 7);
    exp_push("abort_overrun_set", 1); cmp(32'(overrun));

    // Checksum error
    cur_blk = good_blk;
    cur_blk[100] = cur_blk[100] + 8'd1;
    do_start();
    send_range(0, 127);
    exp_push("ck_done", 1);     cmp(32'(done));
    exp_push("ck_header", 1);   cmp(32'(header_ok));
    exp_push("ck_bad", 0);      cmp(32'(checksum_ok));

    // Restart after 60 bytes
    cur_blk = good_blk;
    do_start();
    send_range(0, 59);
    exp_push("part_busy", 1);    cmp(32'(busy));
    exp_push("part_idx", 60);    cmp(32'(byte_idx));
    exp_push("part_pclk", 32'h3A02); cmp(32'(pixel_clk_10khz));
    do_start();
    exp_push("restart_pclk", 0);   cmp(32'(pixel_clk_10khz));
    exp_push("restart_mfg", 0);    cmp(32'(mfg_id));
    exp_push("restart_header", 0); cmp(32'(header_ok));
    exp_push("restart_idx", 0);    cmp(32'(byte_idx));
    send_range(0, 127);
    check_good(1'b1);

    // start and byte_valid together from DONE
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h00;
    tick();
    start = 1'b0; byte_valid = 1'b0;
    $display("collision byte_idx=%0d busy=%0b", byte_idx, busy);
    exp_push("coll_idx", 0);     cmp(32'(byte_idx));
    exp_push("coll_busy", 1);    cmp(32'(busy));
    exp_push("coll_done", 0);    cmp(32'(done));
    exp_push("coll_overrun", 0); cmp(32'(overrun));
    send_range(0, 39);
    exp_push("pre_rst_idx", 40); cmp(32'(byte_idx));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("midrst");
    send_byte(8'h00);
    exp_push("idle_busy", 0);    cmp(32'(busy));
    exp_push("idle_idx", 0);     cmp(32'(byte_idx));
    exp_push("idle_overrun", 0); cmp(32'(overrun));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/edid_block_parser.md
Name: edid_block_parser

Overview:
- Consumes the byte stream produced by the DDC/I2C read master on the gpdi port, one 128-byte EDID base block per transaction.
- Checks the 8-byte EDID header and the block checksum.
- Extracts the monitor identity and the first detailed timing descriptor (DTD) into registers for the LED/debug logic and the video timing logic.
- Sits directly downstream of the I2C master, in the same clock domain as its byte strobe.

Parameters:
- BLOCK_BYTES, 128: bytes per EDID block; the byte counter wraps/terminates at this value.
- DTD_OFFSET, 54: byte offset of the first detailed timing descriptor.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle pulse that clears results and arms the parser for a new block.
- byte_valid  input  1  single-cycle strobe; byte_data is valid this cycle.
- byte_data  input  8  received EDID byte, in address order from offset 0.
- busy  output  1  armed and waiting for or receiving bytes.
- done  output  1  level; set when parsing finishes, cleared by start or reset.
- header_ok  output  1  bytes 0..7 equal 00 FF FF FF FF FF FF 00.
- checksum_ok  output  1  sum of all 128 bytes mod 256 equals 0.
- mfg_id  output  16  {byte8, byte9}.
- product_code  output  16  {byte11, byte10}.
- ext_count  output  8  byte126.
- pixel_clk_10khz  output  16  {byte55, byte54}.
- h_active  output  12  {byte58[7:4], byte56}.
- v_active  output  12  {byte61[7:4], byte59}.
- byte_idx  output  7  index of the next expected byte.
- overrun  output  1  sticky; byte_valid was seen while in DONE or ABORT.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; every output is 0; the checksum accumulator is 0.
- States: IDLE, HEADER, BODY, DONE, ABORT.
- IDLE:
  - byte_valid is ignored.
  - start -> HEADER; byte_idx=0, accumulator=0, all result outputs cleared, busy=1.
- HEADER, on each byte_valid:
  - Compare the byte with the header constant at byte_idx and add it to the accumulator (8-bit wrap); byte_idx increments.
  - On a mismatch -> ABORT: header_ok=0, done=1, busy=0.
  - On a match at byte_idx 7 -> BODY and header_ok=1.
- BODY, on each byte_valid:
  - Add the byte to the accumulator; byte_idx increments.
  - Load each field register when byte_idx equals its offset.
  - At byte_idx = BLOCK_BYTES-1: checksum_ok = (accumulator + byte == 0); done=1; busy=0; state -> DONE.
- Latency: done and checksum_ok are visible the cycle after the last byte_valid. Each field is visible the cycle after its byte.
- byte_idx stays at BLOCK_BYTES-1 in DONE; it never wraps to 0 without a start.
- DONE/ABORT: byte_valid sets overrun=1 and the byte is discarded. start -> HEADER, as from IDLE, and clears overrun.
- start asserted in HEADER or BODY (mid-block): restart with all state cleared; any partial results are discarded.
- start and byte_valid in the same cycle: start wins and the byte is dropped; byte_idx=0 afterwards.
- byte_valid is not back-pressured; the parser accepts one byte per cycle sustained.
- rst_n low mid-block overrides everything and returns to IDLE with outputs cleared.

Optional Feature:
- Macro: EDID_RAW_STORE_EN.
- With the macro defined:
  - Add ports rd_addr (input, 7 bits) and rd_data (output, 8 bits).
  - A 128x8 register array stores every accepted byte at byte_idx.
  - rd_data is registered, with 1-cycle latency from rd_addr.
  - The array contents are not cleared by reset or start; rd_data resets to 0.
  - A read of the address being written in the same cycle returns the old data.
- Without the macro: the ports are absent and no storage is inferred.

Test Plan:
- Valid block: start, then 128 bytes of a real EDID with mfg bytes 0x10,0xAC, product 0x40,0xA0, DTD pixel clock 0x02,0x3A, byte56=0x80, byte58=0x70, byte59=0x38, byte61=0x40, checksum byte corrected.
  - Required: header_ok=1, checksum_ok=1, mfg_id=0x10AC, product_code=0xA040, pixel_clk_10khz=0x3A02, h_active=0x780, v_active=0x438, done=1 one cycle after byte 127.
- Corrupt byte 3 = 0xFE: ABORT the cycle after byte 3; done=1, header_ok=0; the remaining bytes set overrun=1.
- Checksum error: valid block with byte 100 incremented by 1 -> done=1, header_ok=1, checksum_ok=0.
- Restart: start after 60 bytes, then a full valid block -> results match the first scenario; no residue from the aborted block.
- Collision: start and byte_valid (0x00) in the same cycle -> byte dropped, byte_idx=0; reset low at byte 40 -> all outputs 0, state IDLE.
- With EDID_RAW_STORE_EN: after the first scenario, rd_addr=8 -> rd_data=0x10 one cycle later; rd_addr=127 -> the checksum byte.
